// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm and hourly-chime sequencer for the digital clock.
// Compares the running time with the stored alarm time and with the top of
// each hour. Runs a ring / snooze / chime state machine paced by the 1 Hz
// tick, and issues one-cycle beep requests to the buzzer stage.
//
// Ports:
//   clk50mhz    system clock, rising edge
//   rst         synchronous active-high reset
//   sec_tick    one-cycle pulse once per second
//   hour/min/sec        current time (binary)
//   al_hour/al_min      stored alarm time
//   alarm_on, chime_on  enable levels
//   stop_key, snooze_key  debounced one-cycle key presses
//   beepen      one-cycle beep request
//   ringing     high while ringing
//   snoozing    high while snoozing
//   snooze_left snoozes remaining in the current alarm episode
module alarm_ctrl #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk50mhz,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [4:0] al_hour,
  input  logic [5:0] al_min,
  input  logic       alarm_on,
  input  logic       chime_on,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       beepen,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_left
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE, CHIME} state_t;

  state_t     state_q, state_d;
  logic [7:0] ring_cnt, ring_d;
  logic [9:0] snz_cnt, snz_d;
  logic [3:0] chime_cnt, chime_d;
  logic [2:0] left_d;
  logic       beep_d;
  logic       al_d, hr_d;
  logic       al_match, hr_match, al_trig, ch_trig;
  logic [3:0] h12, chime_n;

  always_comb begin
    al_match = (hour == al_hour) && (min == al_min) && (sec == 6'd0);
    hr_match = (min == 6'd0) && (sec == 6'd0);
    // Rising-edge detection so a held match point fires only once.
    al_trig  = al_match && !al_d && alarm_on;
    ch_trig  = hr_match && !hr_d && chime_on;
    h12      = 4'((hour >= 5'd12) ? hour - 5'd12 : hour);
    chime_n  = (h12 == 4'd0) ? 4'd12 : h12;
  end

  // Within a state, branches are ordered by priority:
  // alarm_on drop > stop_key > snooze_key > sec_tick.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_cnt;
    snz_d   = snz_cnt;
    chime_d = chime_cnt;
    left_d  = snooze_left;
    beep_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (al_trig) begin
          state_d = RING;
          ring_d  = '0;
          left_d  = 3'(MAX_SNOOZE);
        end else if (ch_trig) begin
          state_d = CHIME;
          chime_d = chime_n;
        end
      end
      RING: begin
        if (!alarm_on || stop_key) begin
          state_d = IDLE;
        end else if (snooze_key) begin
          if (snooze_left != 3'd0) begin
            state_d = SNOOZE;
            snz_d   = 10'(SNOOZE_SEC);
            left_d  = snooze_left - 3'd1;
          end else begin
            state_d = IDLE;
          end
        end else if (sec_tick) begin
          beep_d = 1'b1;
          ring_d = ring_cnt + 8'd1;
          if (ring_cnt == 8'(RING_SEC - 1)) state_d = IDLE;
        end
      end
      SNOOZE: begin
        if (!alarm_on || stop_key) begin
          state_d = IDLE;
        end else if (sec_tick && !snooze_key) begin
          snz_d = snz_cnt - 10'd1;
          if (snz_cnt == 10'd1) begin
            state_d = RING;
            ring_d  = '0;
          end
        end
      end
      CHIME: begin
        if (al_trig) begin
          state_d = RING;
          ring_d  = '0;
          left_d  = 3'(MAX_SNOOZE);
        end else if (stop_key) begin
          state_d = IDLE;
        end else if (sec_tick && !snooze_key) begin
          beep_d  = 1'b1;
          chime_d = chime_cnt - 4'd1;
          if (chime_cnt == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk50mhz) begin
    if (rst) begin
      state_q     <= IDLE;
      ring_cnt    <= '0;
      snz_cnt     <= '0;
      chime_cnt   <= '0;
      snooze_left <= '0;
      beepen      <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
      al_d        <= 1'b1;
      hr_d        <= 1'b1;
    end else begin
      state_q     <= state_d;
      ring_cnt    <= ring_d;
      snz_cnt     <= snz_d;
      chime_cnt   <= chime_d;
      snooze_left <= left_d;
      beepen      <= beep_d;
      ringing     <= (state_d == RING);
      snoozing    <= (state_d == SNOOZE);
      al_d        <= al_match;
      hr_d        <= hr_match;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed bench for alarm_ctrl. Stimulus pushes expected beep cycles and
// expected status snapshots into queues; a negedge monitor pops and compares.
module tb_alarm_ctrl;

  logic       clk;
  logic       rst;
  logic       sec_tick;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic       alarm_on;
  logic       chime_on;
  logic       stop_key;
  logic       snooze_key;
  logic       beepen;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_left;

  alarm_ctrl #(
    .RING_SEC  (5),
    .SNOOZE_SEC(3),
    .MAX_SNOOZE(2)
  ) dut (
    .clk50mhz   (clk),
    .rst        (rst),
    .sec_tick   (sec_tick),
    .hour       (hour),
    .min        (min),
    .sec        (sec),
    .al_hour    (al_hour),
    .al_min     (al_min),
    .alarm_on   (alarm_on),
    .chime_on   (chime_on),
    .stop_key   (stop_key),
    .snooze_key (snooze_key),
    .beepen     (beepen),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .snooze_left(snooze_left)
  );

  typedef struct {
    int         cyc;
    logic       r;
    logic       s;
    logic [2:0] sl;
  } st_t;

  int  beep_q[$];
  st_t st_q[$];
  int  cyc = 0;
  int  vectors = 0;
  int  miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: all comparisons happen here.
  always @(negedge clk) begin
    st_t e;
    while (beep_q.size() > 0 && beep_q[0] < cyc) begin
      vectors++;
      miscompares++;
      $display("FAIL beep_missing: beepen=0 at cycle %0d, required 1", beep_q[0]);
      void'(beep_q.pop_front());
    end
    if (beepen) begin
      vectors++;
      if (beep_q.size() > 0 && beep_q[0] == cyc) begin
        void'(beep_q.pop_front());
      end else begin
        miscompares++;
        $display("FAIL beep_unexpected: beepen=1 at cycle %0d, required 0", cyc);
      end
    end
    while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
      e = st_q.pop_front();
      vectors++;
      if (e.cyc != cyc || ringing !== e.r || snoozing !== e.s || snooze_left !== e.sl) begin
        miscompares++;
        $display("FAIL status@%0d: ringing/snoozing/snooze_left got %b/%b/%0d required %b/%b/%0d",
                 e.cyc, ringing, snoozing, snooze_left, e.r, e.s, e.sl);
      end
    end
  end

  task automatic cyc_in(input logic t, input logic sp, input logic sz);
    sec_tick   = t;
    stop_key   = sp;
    snooze_key = sz;
    @(posedge clk);
    #1;
    sec_tick   = 1'b0;
    stop_key   = 1'b0;
    snooze_key = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_in(1'b0, 1'b0, 1'b0);
  endtask

  // Expected outputs after the next clock edge.
  task automatic exp_st(input logic r, input logic s, input logic [2:0] sl);
    st_t e;
    e.cyc = cyc + 1;
    e.r   = r;
    e.s   = s;
    e.sl  = sl;
    st_q.push_back(e);
  endtask

  task automatic beep_tick();
    beep_q.push_back(cyc + 1);
    cyc_in(1'b1, 1'b0, 1'b0);
  endtask

  task automatic quiet_tick();
    cyc_in(1'b1, 1'b0, 1'b0);
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hour = h;
    min  = m;
    sec  = s;
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
    alarm_on = 1'b1; chime_on = 1'b0; al_hour = 5'd7; al_min = 6'd30;
    set_time(5'd7, 6'd30, 6'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset with the time sitting on the alarm point: no trigger afterwards.
    exp_st(1'b0, 1'b0, 3'd0); idle(1);
    rst = 1'b0;
    exp_st(1'b0, 1'b0, 3'd0); idle(1);
    exp_st(1'b0, 1'b0, 3'd0); idle(1);
    quiet_tick(); idle(2);

    // Alarm 07:30: RING on next cycle, 5 beeps, then IDLE; holding does not retrigger.
    set_time(5'd7, 6'd29, 6'd59); idle(2);
    set_time(5'd7, 6'd30, 6'd0);
    exp_st(1'b1, 1'b0, 3'd2); idle(1);
    repeat (4) begin beep_tick(); idle(2); end
    exp_st(1'b1, 1'b0, 3'd2); idle(1);
    exp_st(1'b0, 1'b0, 3'd2); beep_tick(); idle(3);
    exp_st(1'b0, 1'b0, 3'd2); quiet_tick(); idle(2);

    // Snooze, re-ring with counter restarted, key on tick, exhaustion acts as stop.
    set_time(5'd7, 6'd29, 6'd59); idle(2);
    set_time(5'd7, 6'd30, 6'd0);
    exp_st(1'b1, 1'b0, 3'd2); idle(2);
    beep_tick(); idle(1);
    exp_st(1'b0, 1'b1, 3'd1); cyc_in(1'b0, 1'b0, 1'b1); idle(1);
    quiet_tick(); idle(1);
    exp_st(1'b0, 1'b1, 3'd1); quiet_tick(); idle(1);
    exp_st(1'b1, 1'b0, 3'd1); quiet_tick(); idle(1);
    repeat (4) begin beep_tick(); idle(1); end
    exp_st(1'b1, 1'b0, 3'd1); idle(1);
    exp_st(1'b0, 1'b1, 3'd0); cyc_in(1'b1, 1'b0, 1'b1); idle(1);
    quiet_tick(); idle(1);
    quiet_tick(); idle(1);
    exp_st(1'b1, 1'b0, 3'd0); quiet_tick(); idle(1);
    beep_tick(); idle(1);
    exp_st(1'b0, 1'b0, 3'd0); cyc_in(1'b0, 1'b0, 1'b1); idle(2);
    exp_st(1'b0, 1'b0, 3'd0); quiet_tick(); idle(1);
    set_time(5'd7, 6'd31, 6'd0); idle(1);

    // Chime at 15:00 -> 3 beeps, at 00:00 -> 12 beeps.
    chime_on = 1'b1;
    set_time(5'd14, 6'd59, 6'd59); idle(2);
    set_time(5'd15, 6'd0, 6'd0); idle(1);
    repeat (3) begin beep_tick(); idle(1); end
    exp_st(1'b0, 1'b0, 3'd0); quiet_tick(); idle(1);
    quiet_tick(); idle(1);
    set_time(5'd23, 6'd59, 6'd59); idle(2);
    set_time(5'd0, 6'd0, 6'd0); idle(1);
    repeat (12) begin beep_tick(); idle(1); end
    quiet_tick(); idle(1);
    quiet_tick(); idle(1);

    // Alarm at 08:00 with chime enabled: RING only; stop+snooze together -> IDLE.
    al_hour = 5'd8; al_min = 6'd0;
    set_time(5'd7, 6'd59, 6'd59); idle(2);
    set_time(5'd8, 6'd0, 6'd0);
    exp_st(1'b1, 1'b0, 3'd2); idle(2);
    exp_st(1'b0, 1'b0, 3'd2); cyc_in(1'b0, 1'b1, 1'b1); idle(1);
    repeat (3) begin quiet_tick(); idle(1); end

    // alarm_on dropped while ringing, coinciding with a tick: IDLE, no beep.
    set_time(5'd7, 6'd59, 6'd59); idle(2);
    set_time(5'd8, 6'd0, 6'd0);
    exp_st(1'b1, 1'b0, 3'd2); idle(2);
    beep_tick(); idle(1);
    alarm_on = 1'b0;
    exp_st(1'b0, 1'b0, 3'd2); quiet_tick();
    alarm_on = 1'b1; idle(2);
    quiet_tick(); idle(1);

    // Reset in RING: all outputs clear on the next cycle, no beep, no retrigger.
    set_time(5'd7, 6'd59, 6'd59); idle(2);
    set_time(5'd8, 6'd0, 6'd0);
    exp_st(1'b1, 1'b0, 3'd2); idle(2);
    beep_tick(); idle(1);
    rst = 1'b1;
    exp_st(1'b0, 1'b0, 3'd0); quiet_tick();
    rst = 1'b0;
    exp_st(1'b0, 1'b0, 3'd0); idle(1);
    exp_st(1'b0, 1'b0, 3'd0); quiet_tick(); idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Alarm and hourly-chime sequencer for the digital clock. It compares the running time against the stored alarm time and the top of each hour, and runs a ring / snooze / chime state machine timed by the 1 Hz tick. It emits one-cycle `beepen` requests that the downstream buzzer stage turns into tone bursts. It sits between the timekeeping/alarm-setting logic and the buzzer.

## Interface
Parameters:
- `RING_SEC`, 60: number of beeps per ring episode (1..255)
- `SNOOZE_SEC`, 300: snooze delay in seconds (1..1023)
- `MAX_SNOOZE`, 3: snoozes allowed per alarm episode (0..7)

Ports:
- `clk50mhz` in 1: system clock; all logic on the rising edge
- `rst` in 1: synchronous, active-high reset
- `sec_tick` in 1: one-cycle pulse once per second
- `hour` in 5: current hour, binary 0..23
- `min` in 6: current minute, 0..59
- `sec` in 6: current second, 0..59
- `al_hour` in 5: alarm hour
- `al_min` in 6: alarm minute
- `alarm_on` in 1: alarm armed (level)
- `chime_on` in 1: hourly chime enabled (level)
- `stop_key` in 1: debounced one-cycle press; stop ringing or snooze
- `snooze_key` in 1: debounced one-cycle press; snooze
- `beepen` out 1: one-cycle beep request to the buzzer
- `ringing` out 1: high in RING
- `snoozing` out 1: high in SNOOZE
- `snooze_left` out 3: snoozes remaining in the current episode

## Operation
- States: IDLE, RING, SNOOZE, CHIME. State and all outputs are registered.
- `al_match` = (`hour`==`al_hour`) & (`min`==`al_min`) & (`sec`==0). `hr_match` = (`min`==0) & (`sec`==0).
- Both match signals are delayed one cycle into `al_d` and `hr_d`.
- Alarm trigger = `al_match` & ~`al_d` & `alarm_on`. Chime trigger = `hr_match` & ~`hr_d` & `chime_on`.
- IDLE:
  - On alarm trigger: go to RING, `ring_cnt`=0, `snooze_left`=MAX_SNOOZE.
  - Otherwise, on chime trigger: go to CHIME, `chime_cnt`=N, where N = `hour` mod 12, with 0 mapped to 12.
- RING, on each `sec_tick`:
  - `beepen`=1 on the next cycle; `ring_cnt`+1.
  - If `ring_cnt`==RING_SEC-1, go to IDLE. This final tick still beeps, so there are RING_SEC beeps in total.
- RING, keys:
  - `stop_key`: go to IDLE.
  - `snooze_key` with `snooze_left`>0: go to SNOOZE, `snz_cnt`=SNOOZE_SEC, `snooze_left`-1.
  - `snooze_key` with `snooze_left`==0: acts as stop.
- SNOOZE, on each `sec_tick`: `snz_cnt`-1. When the tick arrives with `snz_cnt`==1, go to RING with `ring_cnt`=0. No beeps while in SNOOZE.
- SNOOZE, `stop_key`: go to IDLE.
- CHIME, on each `sec_tick`: beep, `chime_cnt`-1. When the tick arrives with `chime_cnt`==1, go to IDLE after that beep.
- CHIME, alarm trigger: aborts the chime and enters RING (as from IDLE). `stop_key` goes to IDLE.
- `alarm_on` low while in RING or SNOOZE: go to IDLE on the next edge.
- Counter widths: `ring_cnt` 8 bits, `snz_cnt` 10 bits, `chime_cnt` 4 bits. No wrap-around is possible within the legal parameter ranges.

## Timing
- Reset:
  - State IDLE; `beepen`=`ringing`=`snoozing`=0; `snooze_left`=0; all counters 0.
  - `al_d`=`hr_d`=1, so a match already present when reset releases does not trigger.
- Trigger latency: a match that rises on cycle T is detected at the edge ending T. `ringing` (or CHIME) is visible at T+1.
- Beep timing: `beepen` is high for exactly the one cycle after each qualifying `sec_tick`. It is never high for two consecutive cycles.
- The first ring beep comes on the first `sec_tick` after entry. There is no beep on the entry cycle.
- Priority within one cycle, highest first: `rst` > `alarm_on` drop > `stop_key` > `snooze_key` > `sec_tick`.
  - A key press coinciding with `sec_tick` suppresses that tick's beep and counting.
- An alarm trigger and a chime trigger in the same cycle: the alarm wins and the chime is discarded.
- A chime trigger while in RING or SNOOZE is ignored.
- Because triggers are edge-based, setting the time so it lands on the match point does fire once. Holding at the match point does not retrigger.
- Reset asserted mid-episode returns the block to IDLE on the next edge. It produces no `beepen` that cycle.

## Test plan
- Alarm 07:30, `alarm_on`=1, clock passes 07:29:59 → 07:30:00, RING_SEC=5: `ringing` rises 1 cycle after the match, then exactly 5 `beepen` pulses on the next 5 ticks, then IDLE.
- Snooze: `snooze_key` during the 2nd ring second with SNOOZE_SEC=3 → `snoozing`=1 and `snooze_left` 3→2; no beeps for 3 ticks; RING re-entered on the 3rd tick; beeps restart with `ring_cnt`=0.
- Snooze exhaustion: MAX_SNOOZE=1, snooze twice → the second `snooze_key` acts as stop; IDLE, `snooze_left`=0.
- Chime: `chime_on`=1, time 14:59:59 → 15:00:00 → 3 beeps on 3 ticks, then IDLE. At 00:00:00 → 12 beeps.
- Conflicts:
  - Alarm at 08:00 with `chime_on`=1 → RING only, no chime beeps.
  - `stop_key` and `snooze_key` in the same cycle → IDLE.
  - Key press on a tick cycle → no `beepen`.
- Reset with the time equal to the alarm time → no trigger after release. `rst` asserted in RING → all outputs 0 on the next cycle.
